mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit multiplexer between four requesters.
- Grants exactly one requester at a time.
- Drives the mux select `sel[1:0]` and a qualifying `sel_valid` flag.
- Sits directly in front of the mux; `sel` connects straight to the mux select input.

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner when the timeout feature is compiled in. Legal range 2..2^CNT_W.
- `CNT_W`, default 4: width of the hold counter.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset.
- `req`  input  4  request vector; `req[i]` is high while requester i wants the mux.
- `gnt`  output  4  registered one-hot grant; all-zero when idle.
- `sel`  output  2  registered mux select; equals the index of the set `gnt` bit.
- `sel_valid`  output  1  registered; high exactly when `gnt` is non-zero.
- `busy`  output  1  registered; high in GRANT state (mirrors `sel_valid`).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (`rst_n`).
- Reset values:
  - `gnt` = 4'b0000, `sel` = 2'b00, `sel_valid` = 0, `busy` = 0.
  - State = IDLE, round-robin pointer `ptr` = 0, hold counter = 0.
- Reset asserted mid-grant clears all outputs immediately (asynchronously), not at the next edge.
- State machine, two states:
  - IDLE:
    - If `req` ≠ 0 at a rising edge, select the winner: the first set bit searching `ptr`, `ptr`+1, … modulo 4.
    - At that same edge: `gnt` = onehot(winner), `sel` = winner, `sel_valid` = 1, state → GRANT, counter → 0.
    - If `req` = 0, stay in IDLE and hold all outputs.
  - GRANT, owner o = `sel`:
    - `req[o]` = 1: keep the grant; counter increments (timeout feature only).
    - `req[o]` = 0, another `req` bit set: handover at this edge with no idle bubble. New winner is the first set bit searching o+1, o+2, o+3 modulo 4. `gnt`/`sel` update, `sel_valid` stays 1, counter → 0.
    - `req[o]` = 0, no other request: `gnt` → 0, `sel_valid` → 0, state → IDLE. `sel` holds o (do not care while invalid).
- Pointer update: on every grant or handover, `ptr` ← winner + 1 modulo 4. This guarantees fairness: no requester is skipped more than 3 grants.
- Latency: request to grant is 1 clock edge. Release to handover is 1 clock edge.
- `gnt` is never multi-hot. `sel` never changes while `sel_valid` = 1 unless `gnt` changes in the same cycle.
- Requests are level-sensitive. A requester that drops `req` without having been granted simply loses its place; nothing is queued.
- Owner drops `req` and re-raises it in the next cycle with no competitors: path is GRANT → IDLE → GRANT, i.e. one bubble cycle.

Optional Feature:
- Macro: `MUX4_RR_ARB_TIMEOUT_EN`.
- Defined:
  - The hold counter is present.
  - In GRANT with `req[o]` = 1 and counter = `MAX_HOLD`-1:
    - If any other `req` bit is set, forced handover at that edge using the normal search from o+1; `ptr` updates.
    - If no other request, the owner keeps the grant and the counter resets to 0.
- Undefined:
  - No counter logic.
  - The owner holds the grant indefinitely while `req[o]` = 1.

Test Plan:
- Reset: assert `rst_n`=0 mid-grant (`gnt`=0100) → `gnt`=0000, `sel_valid`=0 without waiting for a clock edge. Release; first `req`=1111 → `gnt`=0001, `sel`=00 after 1 edge.
- Round-robin order: hold `req`=1111; each owner drops its `req` for 1 cycle then re-raises → grant sequence 0,1,2,3,0. Each handover completes in 1 edge with `sel_valid` continuously 1.
- Pointer wrap: after owner 2 releases with `req`=0011 → next `gnt`=0001 (search 3,0,1; 3 not requesting).
- Idle transition: single requester 1 drops `req` → next edge `gnt`=0000, `sel_valid`=0, `busy`=0. Re-raise → `gnt`=0010 one edge later.
- Timeout, with `MUX4_RR_ARB_TIMEOUT_EN`, `MAX_HOLD`=4:
  - `req`=0011 held constant → `gnt` alternates 0001 ×4 cycles, 0010 ×4 cycles.
  - `req`=0001 alone → `gnt` stays 0001 indefinitely.
- Without the macro: `req`=0011 held constant for 50 cycles → `gnt` stays 0001 throughout. Check the one-hot assertion every cycle.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving the select of a shared 4:1 mux.
// Define MUX4_RR_ARB_TIMEOUT_EN to limit each grant to MAX_HOLD cycles when others wait.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt, sel_nxt, win;
    logic [3:0] gnt_nxt;
    logic [2:0] pick_idle, pick_hand;
    logic       vld_nxt, take, drop, hold_expired;

    if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_max_hold
        $error("MAX_HOLD must lie in 2..2**CNT_W");
    end

    // {found, index} of the first set bit scanning start, start+1, ... modulo 4
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--)
            if (mask[start + 2'(i)]) r = {1'b1, start + 2'(i)};
        return r;
    endfunction

`ifdef MUX4_RR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    assign hold_expired = (state == GRANT) && (cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (take || hold_expired)
            cnt <= '0;
        else if (state == GRANT)
            cnt <= cnt + 1'b1;
`else
    assign hold_expired = 1'b0;
`endif

    // The handover search excludes the current owner so it covers o+1..o+3 only
    always_comb begin
        pick_idle = rr_pick(req, ptr);
        pick_hand = rr_pick(req & ~(4'b0001 << sel), sel + 2'd1);
        take      = (state == IDLE) ? pick_idle[2] : (!req[sel] || hold_expired) && pick_hand[2];
        win       = (state == IDLE) ? pick_idle[1:0] : pick_hand[1:0];
        drop      = (state == GRANT) && !req[sel] && !pick_hand[2];
        state_nxt = take ? GRANT : drop ? IDLE : state;
        ptr_nxt   = take ? win + 2'd1 : ptr;
        gnt_nxt   = take ? 4'b0001 << win : drop ? 4'b0000 : gnt;
        sel_nxt   = take ? win : sel;
        vld_nxt   = take || (sel_valid && !drop);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            sel       <= sel_nxt;
            sel_valid <= vld_nxt;
        end

    assign busy = (state == GRANT);
endmodule
